valid_rate_gen: RTL and testbench
=================================

Name: valid_rate_gen

Overview:
- Producer of the one-cycle valid/step pulse consumed by the LED shift-register stage of the LED practical.
- Divides the system clock down to one of four switch-selected rates.
- Provides a manual single-step mode driven by a push button.
- Sits between the board switches/buttons and the shift register's i_valid input.

Parameters:
- NB_COUNTER, 32: width of the prescaler counter.
- LIMIT_R0, 1_000_000: period in clock cycles for rate 0.
- LIMIT_R1, 2_000_000: period in clock cycles for rate 1.
- LIMIT_R2, 4_000_000: period in clock cycles for rate 2.
- LIMIT_R3, 8_000_000: period in clock cycles for rate 3.

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_enable  input  1  1 = free-running mode, 0 = idle/manual-step mode.
- i_sel  input  2  rate select: 0..3 map to LIMIT_R0..LIMIT_R3.
- i_step  input  1  manual step button, already synchronised to clock.
- o_valid  output  1  registered one-cycle pulse; connects to the shift register's i_valid.

Behaviour:
- Clocking and reset: single clock domain. Reset is synchronous and active-high (i_reset sampled on the clock rising edge) and has priority over everything.
- Reset values:
  - state = IDLE, counter = 0, o_valid = 0, sel_q = 0.
  - step_q = 1, so a button held through reset release produces no pulse.
- Limits:
  - All LIMIT_Rx must satisfy 2 <= LIMIT_Rx <= 2^NB_COUNTER - 1; elaboration asserts this.
  - Terminal count is LIMIT - 1 of the selected rate, compared at NB_COUNTER width.
- State machine, two states:
  - IDLE: counter held at 0; o_valid driven only by step-edge detection.
    - Go to RUN when i_enable = 1; counter <= 0 and o_valid <= 0 on that edge (E0).
  - RUN, on each edge:
    - If counter >= terminal count: counter <= 0, o_valid <= 1.
    - Else: counter <= counter + 1, o_valid <= 0.
    - Go to IDLE when i_enable = 0; counter <= 0, o_valid <= 0 on that edge. A pulse pending in the same cycle is dropped.
- Timing: with limit L, the first pulse is visible after edge E0 + L, then every L edges. Period is exactly L cycles and pulse width is exactly 1 cycle.
- Rate change:
  - sel_q registers i_sel every cycle.
  - When i_sel != sel_q in RUN: counter <= 0 and o_valid <= 0 on that edge. The new period is counted from that edge.
  - The >= compare protects against any stale counter value.
- Manual step:
  - step_q <= i_step every cycle.
  - In IDLE, i_step = 1 with step_q = 0 gives o_valid <= 1 on that edge, as a single cycle. A held button gives one pulse only.
  - In RUN, i_step is ignored (edge history is still tracked).
- Simultaneous events:
  - Reset beats everything.
  - An enable transition beats a step edge: a step edge on the IDLE->RUN edge is dropped.
  - A rate change beats terminal count.
- No combinational path from any input to o_valid.

Decomposition:
- Package valid_rate_pkg:
  - State encoding: ST_IDLE = 1'b0, ST_RUN = 1'b1.
  - Rate-select codes SEL_R0..SEL_R3.
  - A function mapping a 2-bit select to its limit.
- Sub-module edge_rise_det:
  - Ports: clock, i_reset, i_sig, o_rise.
  - One registered history bit with reset value 1.
  - o_rise = i_sig & ~history.
  - Used for i_step.

Test Plan (LIMIT_R0..R3 overridden to 4, 8, 16, 32):
- Reset pulse, then i_enable = 1, i_sel = 0 sampled at E0 -> o_valid high for one cycle after E4, E8, E12; low on every other edge.
- RUN with i_sel = 1, then i_sel changed to 3 after E5 edge counted from RUN entry -> no pulse at E8; counter restarts; next pulse exactly 32 edges after the change edge.
- i_enable dropped at E3 of a rate-0 period -> o_valid stays 0; counter returns to 0. Re-enable -> first pulse 4 edges after the re-entry edge.
- IDLE, i_step held high for 10 cycles -> exactly one o_valid pulse, on the edge after the rising input. Release and press again -> a second single pulse.
- i_step held high through i_reset and released afterwards -> no pulse. i_reset asserted mid-RUN -> o_valid = 0 and IDLE on the next edge, with i_enable = 1 re-entering RUN one edge after reset deasserts.
- i_step rising in RUN -> no extra pulse; periodic pulses keep their exact 4-cycle spacing.

Source files
------------

// File: rtl/valid_rate_pkg.sv
// Shared types and helpers for the valid/step pulse generator.
package valid_rate_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SEL_R0 = 2'd0,
    SEL_R1 = 2'd1,
    SEL_R2 = 2'd2,
    SEL_R3 = 2'd3
  } rate_sel_e;

  function automatic logic [63:0] sel_limit(input logic [1:0] sel,
                                            input logic [63:0] l0,
                                            input logic [63:0] l1,
                                            input logic [63:0] l2,
                                            input logic [63:0] l3);
    logic [63:0] lim;
    lim = l0;
    unique case (sel)
      SEL_R0:  lim = l0;
      SEL_R1:  lim = l1;
      SEL_R2:  lim = l2;
      SEL_R3:  lim = l3;
      default: lim = l0;
    endcase
    return lim;
  endfunction

endpackage

// File: rtl/edge_rise_det.sv
// Rising-edge detector; history resets high so a level held through reset is not an edge.
module edge_rise_det (
  input  logic clock,
  input  logic i_reset,
  input  logic i_sig,
  output logic o_rise
);

  logic hist;

  always_ff @(posedge clock) begin
    if (i_reset) hist <= 1'b1;
    else         hist <= i_sig;
  end

  assign o_rise = i_sig & ~hist;

endmodule

// File: rtl/valid_rate_gen.sv
// One-cycle valid pulse generator: switch-selected periodic rate or manual push-button step.
module valid_rate_gen
  import valid_rate_pkg::*;
#(
  parameter int unsigned NB_COUNTER = 32,
  parameter int unsigned LIMIT_R0   = 1_000_000,
  parameter int unsigned LIMIT_R1   = 2_000_000,
  parameter int unsigned LIMIT_R2   = 4_000_000,
  parameter int unsigned LIMIT_R3   = 8_000_000
) (
  input  logic       clock,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic [1:0] i_sel,
  input  logic       i_step,
  output logic       o_valid
);

  localparam logic [63:0] MAX_LIM = (64'd1 << NB_COUNTER) - 64'd1;

  generate
    if (64'(LIMIT_R0) < 64'd2 || 64'(LIMIT_R0) > MAX_LIM ||
        64'(LIMIT_R1) < 64'd2 || 64'(LIMIT_R1) > MAX_LIM ||
        64'(LIMIT_R2) < 64'd2 || 64'(LIMIT_R2) > MAX_LIM ||
        64'(LIMIT_R3) < 64'd2 || 64'(LIMIT_R3) > MAX_LIM) begin : g_bad_limit
      $error("valid_rate_gen: every LIMIT_Rx must be in [2, 2^NB_COUNTER-1]");
    end
  endgenerate

  state_e                state, state_n;
  logic [NB_COUNTER-1:0] counter, counter_n, term;
  logic                  valid_n;
  logic [1:0]            sel_q;
  logic                  step_rise;

  edge_rise_det u_step_det (
    .clock  (clock),
    .i_reset(i_reset),
    .i_sig  (i_step),
    .o_rise (step_rise)
  );

  assign term = NB_COUNTER'(sel_limit(sel_q, 64'(LIMIT_R0), 64'(LIMIT_R1),
                                      64'(LIMIT_R2), 64'(LIMIT_R3)) - 64'd1);

  // Priority in RUN: disable, then rate change, then terminal count.
  always_comb begin
    state_n   = state;
    counter_n = counter;
    valid_n   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        counter_n = '0;
        if (i_enable) state_n = ST_RUN;
        else          valid_n = step_rise;
      end
      ST_RUN: begin
        if (!i_enable) begin
          state_n   = ST_IDLE;
          counter_n = '0;
        end else if (i_sel != sel_q) begin
          counter_n = '0;
        end else if (counter >= term) begin
          counter_n = '0;
          valid_n   = 1'b1;
        end else begin
          counter_n = counter + NB_COUNTER'(1);
        end
      end
      default: begin
        state_n   = ST_IDLE;
        counter_n = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      state   <= ST_IDLE;
      counter <= '0;
      o_valid <= 1'b0;
      sel_q   <= 2'b00;
    end else begin
      state   <= state_n;
      counter <= counter_n;
      o_valid <= valid_n;
      sel_q   <= i_sel;
    end
  end

endmodule

// File: tb/tb_valid_rate_gen.sv
// Bench for valid_rate_gen: directed scenarios plus random traffic against an edge-index model.
module tb_valid_rate_gen;

  logic       clock    = 1'b0;
  logic       i_reset  = 1'b1;
  logic       i_enable = 1'b0;
  logic [1:0] i_sel    = 2'd0;
  logic       i_step   = 1'b0;
  logic       o_valid;

  int total = 0;
  int bad   = 0;

  valid_rate_gen #(
    .NB_COUNTER(32),
    .LIMIT_R0  (4),
    .LIMIT_R1  (8),
    .LIMIT_R2  (16),
    .LIMIT_R3  (32)
  ) dut (
    .clock   (clock),
    .i_reset (i_reset),
    .i_enable(i_enable),
    .i_sel   (i_sel),
    .i_step  (i_step),
    .o_valid (o_valid)
  );

  always #5 clock = ~clock;

  // Model: in RUN a pulse lands on every edge whose distance from the period
  // origin (entry or rate-change edge) is a nonzero multiple of the period.
  bit         m_run       = 1'b0;
  int         m_edge      = 0;
  int         m_start     = 0;
  int         m_len       = 4;
  bit         m_prev_step = 1'b1;
  logic [1:0] m_prev_sel  = 2'd0;
  bit         exp_valid   = 1'b0;

  function automatic int lim_of(input logic [1:0] s);
    return 4 << s;
  endfunction

  task automatic cyc();
    @(posedge clock);
    m_edge++;
    if (i_reset) begin
      m_run = 1'b0; exp_valid = 1'b0; m_prev_step = 1'b1; m_prev_sel = 2'd0;
    end else begin
      if (!m_run) begin
        if (i_enable) begin
          m_run = 1'b1; m_start = m_edge; m_len = lim_of(i_sel); exp_valid = 1'b0;
        end else begin
          exp_valid = i_step && !m_prev_step;
        end
      end else if (!i_enable) begin
        m_run = 1'b0; exp_valid = 1'b0;
      end else if (i_sel != m_prev_sel) begin
        m_start = m_edge; m_len = lim_of(i_sel); exp_valid = 1'b0;
      end else begin
        exp_valid = ((m_edge - m_start) % m_len) == 0;
      end
      m_prev_step = i_step;
      m_prev_sel  = i_sel;
    end
    #1;
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_enable = 1'b0; i_step = 1'b0; i_sel = 2'd0;
    repeat (2) cyc();
    total++;
    if (o_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid got=%b want=0", o_valid);
    end
    i_reset = 1'b0;
    cyc();
    total++;
    if (o_valid !== exp_valid) begin
      bad++; $display("FAIL reset_idle got=%b want=%b", o_valid, exp_valid);
    end
  endtask

  task automatic test_periodic();
    logic [12:0] mask;
    logic [12:0] want;
    mask = '0;
    want = 13'b1_0001_0001_0000;
    i_sel = 2'd0; i_enable = 1'b1;
    for (int k = 0; k < 13; k++) begin
      cyc();
      total++;
      if (o_valid !== exp_valid) begin
        bad++; $display("FAIL periodic k=%0d got=%b want=%b", k, o_valid, exp_valid);
      end
      mask[k] = o_valid;
    end
    total++;
    if (mask !== want) begin
      bad++; $display("FAIL periodic_mask got=%b want=%b", mask, want);
    end
    i_enable = 1'b0;
    cyc();
  endtask

  task automatic test_rate_change();
    int first;
    first = -1;
    i_enable = 1'b0; i_sel = 2'd1;
    cyc();
    i_enable = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc();
      total++;
      if (o_valid !== exp_valid) begin
        bad++; $display("FAIL rate_pre k=%0d got=%b want=%b", k, o_valid, exp_valid);
      end
    end
    i_sel = 2'd3;
    for (int k = 0; k < 40; k++) begin
      cyc();
      total++;
      if (o_valid !== exp_valid) begin
        bad++; $display("FAIL rate_post k=%0d got=%b want=%b", k, o_valid, exp_valid);
      end
      if (o_valid === 1'b1 && first < 0) first = k;
    end
    total++;
    if (first != 32) begin
      bad++; $display("FAIL rate_first_pulse got=%0d want=32", first);
    end
    i_enable = 1'b0;
    cyc();
  endtask

  task automatic test_disable();
    int first;
    first = -1;
    i_sel = 2'd0;
    cyc();
    i_enable = 1'b1;
    repeat (3) cyc();
    i_enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      total++;
      if (o_valid !== 1'b0) begin
        bad++; $display("FAIL disable_quiet k=%0d got=%b want=0", k, o_valid);
      end
    end
    i_enable = 1'b1;
    for (int k = 0; k < 9; k++) begin
      cyc();
      total++;
      if (o_valid !== exp_valid) begin
        bad++; $display("FAIL reenable k=%0d got=%b want=%b", k, o_valid, exp_valid);
      end
      if (o_valid === 1'b1 && first < 0) first = k;
    end
    total++;
    if (first != 4) begin
      bad++; $display("FAIL reenable_first got=%0d want=4", first);
    end
    i_enable = 1'b0;
    cyc();
  endtask

  task automatic test_step();
    int cnt;
    int first;
    cnt = 0; first = -1;
    i_enable = 1'b0; i_step = 1'b0;
    repeat (2) cyc();
    i_step = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc();
      total++;
      if (o_valid !== exp_valid) begin
        bad++; $display("FAIL step_held k=%0d got=%b want=%b", k, o_valid, exp_valid);
      end
      if (o_valid === 1'b1) begin cnt++; if (first < 0) first = k; end
    end
    total++;
    if (cnt != 1 || first != 0) begin
      bad++; $display("FAIL step_single cnt=%0d first=%0d want cnt=1 first=0", cnt, first);
    end
    i_step = 1'b0;
    repeat (2) cyc();
    cnt = 0;
    i_step = 1'b1;
    repeat (3) begin
      cyc();
      if (o_valid === 1'b1) cnt++;
    end
    total++;
    if (cnt != 1) begin
      bad++; $display("FAIL step_second cnt=%0d want=1", cnt);
    end
    i_step = 1'b0;
    cyc();
  endtask

  task automatic test_step_through_reset();
    int cnt;
    cnt = 0;
    i_step = 1'b1; i_reset = 1'b1;
    repeat (2) cyc();
    i_reset = 1'b0;
    repeat (3) begin
      cyc();
      if (o_valid === 1'b1) cnt++;
    end
    i_step = 1'b0;
    repeat (2) begin
      cyc();
      if (o_valid === 1'b1) cnt++;
    end
    total++;
    if (cnt != 0) begin
      bad++; $display("FAIL step_through_reset cnt=%0d want=0", cnt);
    end
  endtask

  task automatic test_reset_mid_run();
    int first;
    first = -1;
    i_sel = 2'd0; i_enable = 1'b1;
    repeat (6) cyc();
    i_reset = 1'b1;
    cyc();
    total++;
    if (o_valid !== 1'b0) begin
      bad++; $display("FAIL reset_mid_run got=%b want=0", o_valid);
    end
    i_reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      total++;
      if (o_valid !== exp_valid) begin
        bad++; $display("FAIL post_reset k=%0d got=%b want=%b", k, o_valid, exp_valid);
      end
      if (o_valid === 1'b1 && first < 0) first = k;
    end
    total++;
    if (first != 4) begin
      bad++; $display("FAIL post_reset_first got=%0d want=4", first);
    end
    i_enable = 1'b0;
    cyc();
  endtask

  task automatic test_step_in_run();
    int cnt;
    cnt = 0;
    i_sel = 2'd0; i_enable = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      i_step = 1'($urandom_range(0, 1));
      cyc();
      total++;
      if (o_valid !== exp_valid) begin
        bad++; $display("FAIL step_in_run k=%0d got=%b want=%b", k, o_valid, exp_valid);
      end
      if (o_valid === 1'b1) begin
        cnt++;
        if (k % 4 != 0) begin
          total++; bad++; $display("FAIL step_in_run_spacing k=%0d got=pulse want=none", k);
        end
      end
    end
    total++;
    if (cnt != 5) begin
      bad++; $display("FAIL step_in_run_count got=%0d want=5", cnt);
    end
    i_step = 1'b0; i_enable = 1'b0;
    cyc();
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      i_reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 39) == 0) i_enable = ~i_enable;
      if ($urandom_range(0, 59) == 0) i_sel = 2'($urandom_range(0, 3));
      i_step = ($urandom_range(0, 2) == 0);
      cyc();
      total++;
      if (o_valid !== exp_valid) begin
        bad++; $display("FAIL random k=%0d got=%b want=%b", k, o_valid, exp_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_rate_change();
    test_disable();
    test_step();
    test_step_through_reset();
    test_reset_mid_run();
    test_step_in_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
